// File: rtl/reg_serializer_if.sv
// rtl/reg_serializer_if.sv - parallel-in handshake and serial-out bundle for reg_serializer
interface reg_serializer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_frame;
    logic             ser_strobe;
    logic             busy;
    logic             done;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  ser_out,
        input  ser_frame,
        input  ser_strobe,
        input  busy,
        input  done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output ser_out,
        output ser_frame,
        output ser_strobe,
        output busy,
        output done
    );
endinterface

// File: rtl/reg_serializer.sv
// rtl/reg_serializer.sv - word-to-serial shifter, MSB first, each bit held DIVIDE clocks
module reg_serializer #(
    parameter int WIDTH  = 32,
    parameter int DIVIDE = 4
) (
    input logic             clock,
    input logic             clr,
    reg_serializer_if.slave bus
);
    localparam int DW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIVIDE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [DW-1:0]    div_cnt;
    logic [BW-1:0]    bit_cnt;

    always_ff @(posedge clock) begin
        if (!clr) begin
            state   <= IDLE;
            shreg   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg   <= bus.in_data;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Bit boundary: advance to the next bit, leave after the last period
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        shreg   <= shreg << 1;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // All outputs decode registered state only; in_data never reaches ser_out combinationally
    assign bus.in_ready   = (state == IDLE);
    assign bus.ser_frame  = (state == SHIFT);
    assign bus.ser_out    = (state == SHIFT) && shreg[WIDTH-1];
    assign bus.ser_strobe = (state == SHIFT) && (div_cnt == '0);
    assign bus.busy       = (state == SHIFT) || (state == DONE);
    assign bus.done       = (state == DONE);
endmodule

// File: tb/tb_reg_serializer.sv
// tb/tb_reg_serializer.sv - scoreboard bench for reg_serializer at DIVIDE=4 and DIVIDE=1
module tb_reg_serializer;
    localparam int W = 32;
    localparam int OUT = 5, STB = 4, FRM = 3, BSY = 2, DON = 1, RDY = 0;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         clr      [2];
    logic [W-1:0] tx_data  [2];
    logic         tx_valid [2];
    logic [5:0]   obs      [2];

    reg_serializer_if #(.WIDTH(W)) bus4 ();
    reg_serializer_if #(.WIDTH(W)) bus1 ();

    reg_serializer #(.WIDTH(W), .DIVIDE(4)) dut4 (.clock(clock), .clr(clr[0]), .bus(bus4));
    reg_serializer #(.WIDTH(W), .DIVIDE(1)) dut1 (.clock(clock), .clr(clr[1]), .bus(bus1));

    assign bus4.in_data  = tx_data[0];
    assign bus4.in_valid = tx_valid[0];
    assign bus1.in_data  = tx_data[1];
    assign bus1.in_valid = tx_valid[1];
    assign obs[0] = {bus4.ser_out, bus4.ser_strobe, bus4.ser_frame, bus4.busy, bus4.done, bus4.in_ready};
    assign obs[1] = {bus1.ser_out, bus1.ser_strobe, bus1.ser_frame, bus1.busy, bus1.done, bus1.in_ready};

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [1:0] exp_q [2][$];
    int done_exp   [2] = '{0, 0};
    int done_seen  [2] = '{0, 0};
    int last_done  [2] = '{-10, -10};
    int accept_cyc [2] = '{0, 0};
    int strobes    [2] = '{0, 0};

    function automatic int div_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expected {bit, strobe} per framed cycle and audits each done pulse
    always begin
        @(posedge clock);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (obs[k][FRM]) begin
                check("bit_expected", 32'(exp_q[k].size() != 0), 32'd1);
                if (exp_q[k].size() != 0) begin
                    logic [1:0] e;
                    e = exp_q[k].pop_front();
                    check("ser_out_strobe", {30'd0, obs[k][OUT], obs[k][STB]}, {30'd0, e});
                end
                if (obs[k][STB]) strobes[k]++;
            end
            if (obs[k][DON]) begin
                done_seen[k]++;
                last_done[k] = cyc;
                check("done_expected", 32'(done_exp[k] > 0), 32'd1);
                if (done_exp[k] > 0) done_exp[k]--;
                check("frame_complete", exp_q[k].size(), 32'd0);
                check("strobe_count", strobes[k], W);
                check("done_time", cyc, accept_cyc[k] + W * div_of(k) + 1);
                check("done_outputs", {28'd0, obs[k][OUT], obs[k][FRM], obs[k][BSY], obs[k][RDY]}, 32'b0010);
                strobes[k] = 0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge with in_valid still high
    task automatic accept(input int k, input logic [W-1:0] w, input bit gap_check);
        int n;
        n = 0;
        tx_data[k]  = w;
        tx_valid[k] = 1'b1;
        while (!obs[k][RDY] && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("accept_timeout", 32'(n < 300), 32'd1);
        if (gap_check) check("accept_after_done", cyc, last_done[k] + 1);
        accept_cyc[k] = cyc;
        for (int i = W - 1; i >= 0; i--)
            for (int d = 0; d < div_of(k); d++)
                exp_q[k].push_back({w[i], d == 0});
        done_exp[k]++;
        @(negedge clock);
    endtask

    task automatic wait_frames(input int k);
        int n;
        n = 0;
        while (done_exp[k] != 0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        check("frame_timeout", done_exp[k], 32'd0);
        @(negedge clock);
    endtask

    initial begin
        int base;
        for (int k = 0; k < 2; k++) begin
            clr[k]      = 1'b0;
            tx_valid[k] = 1'b0;
            tx_data[k]  = '0;
        end
        repeat (3) @(negedge clock);
        check("reset_state_div4", {26'd0, obs[0]}, 32'b000001);
        check("reset_state_div1", {26'd0, obs[1]}, 32'b000001);
        clr[0] = 1'b1;
        clr[1] = 1'b1;
        @(negedge clock);

        accept(0, 32'h8000_0001, 1'b0);
        tx_valid[0] = 1'b0;
        wait_frames(0);

        accept(1, 32'hA5A5_A5A5, 1'b0);
        tx_valid[1] = 1'b0;
        wait_frames(1);

        // Word held valid through a frame with different data: second word waits for IDLE
        accept(0, 32'h1234_5678, 1'b0);
        accept(0, 32'hCAFE_F00D, 1'b1);
        tx_valid[0] = 1'b0;
        wait_frames(0);

        base = done_seen[1];
        accept(1, 32'hFFFF_FFFF, 1'b0);
        accept(1, 32'h0000_0000, 1'b1);
        tx_valid[1] = 1'b0;
        wait_frames(1);
        check("b2b_done_pulses", done_seen[1] - base, 32'd2);

        // Abort mid-frame at T+50
        base = done_seen[0];
        accept(0, 32'h0F0F_0F0F, 1'b0);
        tx_valid[0] = 1'b0;
        repeat (49) @(negedge clock);
        clr[0] = 1'b0;
        exp_q[0].delete();
        done_exp[0] = 0;
        @(negedge clock);
        check("abort_outputs", {29'd0, obs[0][FRM], obs[0][RDY], obs[0][BSY]}, 32'b010);
        clr[0] = 1'b1;
        repeat (150) @(negedge clock);
        check("abort_no_done", done_seen[0] - base, 32'd0);

        // Reset wins over in_valid in the same cycle
        tx_data[1]  = 32'hDEAD_BEEF;
        tx_valid[1] = 1'b1;
        clr[1]      = 1'b0;
        @(negedge clock);
        tx_valid[1] = 1'b0;
        check("reset_priority", {26'd0, obs[1]}, 32'b000001);
        clr[1] = 1'b1;
        repeat (40) @(negedge clock);
        check("reset_priority_idle", {26'd0, obs[1]}, 32'b000001);

        check("total_done_div4", done_seen[0], 32'd3);
        check("total_done_div1", done_seen[1], 32'd3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_serializer.md
REG_SERIALIZER -- requirements
Module: reg_serializer

Interface
REQ-001 Parameter WIDTH, default 32: word width in bits.
REQ-002 Parameter DIVIDE, default 4: clock cycles per serial bit period; legal range >= 1.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 clock  input  1  the single clock; all state updates on its rising edge.
REQ-005 clr  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-006 in_data  input  WIDTH  parallel word to transmit.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 ser_out  output  1  serial data, MSB first.
REQ-010 ser_frame  output  1  high for every cycle in which ser_out carries a data bit.
REQ-011 ser_strobe  output  1  one-cycle pulse in the first cycle of each bit period.
REQ-012 busy  output  1  high in SHIFT and DONE states.
REQ-013 done  output  1  one-cycle pulse after the last bit period.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 IDLE outputs: in_ready=1, ser_frame=0, ser_out=0, ser_strobe=0, busy=0, done=0.
REQ-016 Accept: in cycle T, in IDLE, in_valid=1 -> in_data SHALL be captured into a WIDTH-bit shift register, and the state SHALL be SHIFT at T+1.
REQ-017 In IDLE with in_valid=0, the block SHALL stay in IDLE with the shift register unchanged.
REQ-018 SHIFT, first cycle (T+1): ser_frame=1, ser_strobe=1, ser_out=in_data[WIDTH-1].
REQ-019 Each bit SHALL be held for exactly DIVIDE cycles, tracked by a bit-period counter that counts 0..DIVIDE-1.
REQ-020 ser_strobe=1 only when the bit-period counter is 0 and the state is SHIFT.
REQ-021 At counter wrap: shift register shifts left by 1, bit counter increments, next bit presented.
REQ-022 The bit counter SHALL be wide enough to hold WIDTH without overflow.
REQ-023 After WIDTH*DIVIDE SHIFT cycles (cycles T+1..T+WIDTH*DIVIDE), the next state SHALL be DONE.
REQ-024 DONE lasts one cycle (T+WIDTH*DIVIDE+1): done=1, ser_frame=0, ser_out=0, in_ready=0, busy=1.
REQ-025 After DONE, the state SHALL unconditionally return to IDLE.
REQ-026 in_ready=0 throughout SHIFT and DONE; in_valid in those states SHALL be ignored (no capture, no effect).
REQ-027 Back-to-back words: the earliest next accept is the cycle after DONE, giving exactly one idle cycle between frames.
REQ-028 DIVIDE=1: ser_strobe SHALL be high on every SHIFT cycle and the frame SHALL last WIDTH cycles.
REQ-029 All outputs SHALL be driven from registered state or decoded from the state register; there is no combinational path from in_data to ser_out.

Reset
REQ-030 clr=0 at a rising edge -> next cycle: state=IDLE, shift register=0, both counters=0, in_ready=1, all other outputs 0.
REQ-031 Reset SHALL take priority over accept and shift in the same cycle.
REQ-032 Reset mid-SHIFT or in DONE SHALL abort the frame: no done pulse, and the word is discarded.
REQ-033 While clr=0 the block SHALL hold its reset state and ignore in_valid.

Verification
REQ-034 WIDTH=32, DIVIDE=4, send 0x80000001 accepted at T -> ser_out=1 for T+1..T+4, 0 for T+5..T+124, 1 for T+125..T+128; done=1 at T+129; 32 strobes counted.
REQ-035 DIVIDE=1, send 0xA5A5A5A5 -> serial stream 1010_0101 repeated over T+1..T+32; strobe high on all 32 cycles; done at T+33.
REQ-036 Hold in_valid=1 with a new word throughout a frame -> the first word is transmitted unaltered; the second word is accepted only at the first IDLE cycle after done.
REQ-037 Assert clr=0 at T+50 of a DIVIDE=4 frame -> at T+51 ser_frame=0, in_ready=1, busy=0; no done pulse follows.
REQ-038 Two back-to-back words 0xFFFFFFFF then 0x00000000 -> frames separated by exactly one DONE cycle and one IDLE cycle; done pulses exactly twice.
REQ-039 Apply in_valid=1 and clr=0 in the same cycle -> no capture, and the block is in IDLE next cycle.
